// File: rtl/cpu_pkg.sv
// Shared processor constants: PC width, instruction size, reset vector and
// the PC-stage state encoding.
package cpu_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned WORD_SHIFT  = 2;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN           = 1'b0,
    ST_HOLD_REDIRECT = 1'b1
  } pc_state_e;

endpackage : cpu_pkg

// File: rtl/pc_target_adder.sv
// Combinational next-PC arithmetic: sequential PC+4 and the PC-relative
// redirect target built from a signed instruction-word offset.
module pc_target_adder
  import cpu_pkg::*;
#(
  parameter int unsigned OFFSET_W = 8
) (
  input  logic [PC_W-1:0]     pc_i,
  input  logic [OFFSET_W-1:0] offset_i,
  output logic [PC_W-1:0]     pc_plus4_o,
  output logic [PC_W-1:0]     target_o
);

  localparam int unsigned EXT_W = PC_W - OFFSET_W;

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] off_bytes;

  // Word offset -> byte offset; all adds wrap modulo 2^32.
  assign off_ext    = {{EXT_W{offset_i[OFFSET_W-1]}}, offset_i};
  assign off_bytes  = off_ext << WORD_SHIFT;
  assign pc_plus4_o = pc_i + PC_W'(INSTR_BYTES);
  assign target_o   = pc_plus4_o + off_bytes;

endmodule : pc_target_adder

// File: rtl/pc_update_unit.sv
// Program-counter register stage: holds the PC, stalls on I-cache busywait,
// and defers a redirect that resolves during a stall until the stall ends.
module pc_update_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned  OFFSET_W = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                BUSYWAIT,
  input  logic                JUMP,
  input  logic                BRANCH,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  output logic [31:0]         PC,
  output logic [31:0]         PC_PLUS4,
  output logic [31:0]         TARGET,
  output logic                TAKEN,
  output logic                PENDING,
  output logic [31:0]         FETCH_COUNT
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
  logic            pending_q, pending_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;
  logic            taken;

  pc_target_adder #(
    .OFFSET_W (OFFSET_W)
  ) u_adder (
    .pc_i       (pc_q),
    .offset_i   (OFFSET),
    .pc_plus4_o (PC_PLUS4),
    .target_o   (TARGET)
  );

  // Explicit compares so an unknown redirect input never looks taken.
  always_comb begin
    taken = 1'b0;
    if (JUMP == 1'b1) begin
      taken = 1'b1;
    end
    if ((BRANCH == 1'b1) && (ZERO == 1'b1)) begin
      taken = 1'b1;
    end
  end

  assign TAKEN = taken;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    pending_d     = pending_q;
    fetch_cnt_d   = fetch_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (BUSYWAIT == 1'b0) begin
          pc_d        = taken ? TARGET : PC_PLUS4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else if (taken) begin
          pend_target_d = TARGET;
          pending_d     = 1'b1;
          state_d       = ST_HOLD_REDIRECT;
        end
      end
      ST_HOLD_REDIRECT: begin
        // First captured redirect wins; redirects seen now are dropped.
        if (BUSYWAIT == 1'b0) begin
          pc_d        = pend_target_q;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          pending_d   = 1'b0;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_RUN;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      pending_q     <= 1'b0;
      fetch_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      pending_q     <= pending_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign PC          = pc_q;
  assign PENDING     = pending_q;
  assign FETCH_COUNT = fetch_cnt_q;

endmodule : pc_update_unit
